// File: rtl/sar2_logic_param.sv
// Two-step (coarse/fine) SAR conversion controller for the split-capacitor ADC front end.
// Sequences sample, drain, coarse search, boundary decision, fine switchover and fine search.
module sar2_logic_param #(
    parameter int unsigned COARSE_BITS   = 4,
    parameter int unsigned FINE_BITS     = 4,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned DRAIN_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               cnvst_i,
    input  logic                               cont_i,
    input  logic                               cmp_out_i,
    output logic [COARSE_BITS+FINE_BITS-1:0]   sar_o,
    output logic [COARSE_BITS+FINE_BITS-1:0]   dout_o,
    output logic                               eoc_o,
    output logic                               busy_o,
    output logic                               overrun_o,
    output logic                               cmp_clk_o,
    output logic                               s_clk_o,
    output logic                               s_clk_n_o,
    output logic                               drain_sw_o,
    output logic [COARSE_BITS-1:0]             coarse_btm_o,
    output logic                               fine_sel_o,
    output logic                               fine_up_o,
    output logic [FINE_BITS-1:0]               fine_top_a_o,
    output logic [FINE_BITS-1:0]               fine_top_b_o
);

    localparam int unsigned N    = COARSE_BITS + FINE_BITS;
    localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW   = $clog2(SAMPLE_CYCLES + 1);
    localparam int unsigned PMAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int unsigned PW   = $clog2(PMAX + 1);

    localparam logic [N-1:0] SarInit = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [3:0] {
        StIdle, StDrain, StCcmp, StCdec, StBcmp, StBdec, StSwitch, StFcmp, StFdec, StDone
    } state_e;

    state_e               state_q, state_d;
    logic [N-1:0]         sar_q, sar_d;
    logic [N-1:0]         dout_q, dout_d;
    logic                 eoc_q, eoc_d;
    logic                 overrun_q, overrun_d;
    logic                 pending_q, pending_d;
    logic                 fine_sel_q, fine_sel_d;
    logic                 fine_up_q, fine_up_d;
    logic [FINE_BITS-1:0] fta_q, fta_d;
    logic [FINE_BITS-1:0] ftb_q, ftb_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic [PW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;

    logic [N-1:0]         bit_mask;
    logic [FINE_BITS-1:0] fine_mask;

    assign bit_mask  = N'(1) << idx_q;
    assign fine_mask = FINE_BITS'(1) << idx_q;

    always_comb begin
        state_d    = state_q;
        sar_d      = sar_q;
        dout_d     = dout_q;
        eoc_d      = 1'b0;
        overrun_d  = cnvst_i && (state_q != StIdle);
        pending_d  = pending_q;
        fine_sel_d = fine_sel_q;
        fine_up_d  = fine_up_q;
        fta_d      = fta_q;
        ftb_d      = ftb_q;
        samp_d     = samp_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;

        unique case (state_q)
            StIdle: begin
                sar_d      = SarInit;
                fine_sel_d = 1'b0;
                fine_up_d  = 1'b0;
                fta_d      = '0;
                ftb_d      = '0;
                if (samp_q != SW'(SAMPLE_CYCLES)) samp_d = samp_q + SW'(1);
                if (cnvst_i) pending_d = 1'b1;
                if (samp_q == SW'(SAMPLE_CYCLES) && (pending_q || cnvst_i || cont_i)) begin
                    state_d   = StDrain;
                    pending_d = 1'b0;
                    samp_d    = '0;
                    cnt_d     = '0;
                end
            end
            StDrain: begin
                if (cnt_q == PW'(DRAIN_CYCLES - 1)) begin
                    state_d = StCcmp;
                    cnt_d   = '0;
                    idx_d   = IW'(N - 1);
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            StCcmp: state_d = StCdec;
            StCdec: begin
                if (!cmp_out_i) sar_d = sar_d & ~bit_mask;
                if (idx_q > IW'(FINE_BITS)) begin
                    sar_d   = sar_d | (bit_mask >> 1);
                    idx_d   = idx_q - IW'(1);
                    state_d = StCcmp;
                end else begin
                    state_d = StBcmp;
                end
            end
            StBcmp: state_d = StBdec;
            StBdec: begin
                // Boundary compare decides which fine SCA tracks the upper bound
                fine_up_d  = cmp_out_i;
                sar_d      = sar_q | (N'(1) << (FINE_BITS - 1));
                fine_sel_d = 1'b1;
                cnt_d      = '0;
                state_d    = StSwitch;
            end
            StSwitch: begin
                if (cnt_q == PW'(SETTLE_CYCLES - 1)) begin
                    state_d = StFcmp;
                    cnt_d   = '0;
                    idx_d   = IW'(FINE_BITS - 1);
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            StFcmp: state_d = StFdec;
            StFdec: begin
                if (!cmp_out_i) sar_d = sar_d & ~bit_mask;
                if (cmp_out_i ^ fine_up_q) fta_d = fta_q | fine_mask;
                else                       ftb_d = ftb_q | fine_mask;
                if (idx_q != '0) begin
                    sar_d   = sar_d | (bit_mask >> 1);
                    idx_d   = idx_q - IW'(1);
                    state_d = StFcmp;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                dout_d  = sar_q;
                eoc_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            sar_q      <= '0;
            dout_q     <= '0;
            eoc_q      <= 1'b0;
            overrun_q  <= 1'b0;
            pending_q  <= 1'b0;
            fine_sel_q <= 1'b0;
            fine_up_q  <= 1'b0;
            fta_q      <= '0;
            ftb_q      <= '0;
            samp_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            sar_q      <= sar_d;
            dout_q     <= dout_d;
            eoc_q      <= eoc_d;
            overrun_q  <= overrun_d;
            pending_q  <= pending_d;
            fine_sel_q <= fine_sel_d;
            fine_up_q  <= fine_up_d;
            fta_q      <= fta_d;
            ftb_q      <= ftb_d;
            samp_q     <= samp_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
        end
    end

    assign sar_o        = sar_q;
    assign dout_o       = dout_q;
    assign eoc_o        = eoc_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != StIdle);
    assign s_clk_o      = (state_q == StIdle);
    assign s_clk_n_o    = (state_q != StIdle);
    assign cmp_clk_o    = (state_q == StCcmp) || (state_q == StBcmp) || (state_q == StFcmp);
    assign drain_sw_o   = (state_q == StDrain);
    assign coarse_btm_o = sar_q[N-1:FINE_BITS];
    assign fine_sel_o   = fine_sel_q;
    assign fine_up_o    = fine_up_q;
    assign fine_top_a_o = fta_q;
    assign fine_top_b_o = ftb_q;

endmodule

// File: tb/tb_sar2_logic_param.sv
// Bench for sar2_logic_param: default build (A) and a 3+7-bit build (B) sharing one clock,
// driven by an ideal comparator and checked against an arithmetic SAR model.
module tb_sar2_logic_param;

    localparam int CA = 4, FA = 4, NA = 8,  SA = 2, DA = 2, TA = 1;
    localparam int CB = 3, FB = 7, NB = 10, SB = 2, DB = 3, TB = 1;

    logic        clk = 1'b0;
    logic        rst, cnvst, cont, sel;
    logic [15:0] vin;
    int          force_mode;
    int          strobe_n;
    int          checks = 0;
    int          errors = 0;

    logic [NA-1:0] sar_a, dout_a;
    logic [NB-1:0] sar_b, dout_b;
    logic          eoc_a, busy_a, ovr_a, cclk_a, sclk_a, sclkn_a, drain_a, fsel_a, fup_a;
    logic          eoc_b, busy_b, ovr_b, cclk_b, sclk_b, sclkn_b, drain_b, fsel_b, fup_b;
    logic [CA-1:0] cb_a;
    logic [CB-1:0] cb_b;
    logic [FA-1:0] fta_a, ftb_a;
    logic [FB-1:0] fta_b, ftb_b;

    logic [15:0] m_sar, m_dout, m_cb, m_fta, m_ftb;
    logic        m_eoc, m_busy, m_ovr, m_cclk, m_sclk, m_sclkn, m_drain, m_fsel, m_fup;
    logic        cmp;

    always #5 clk = ~clk;

    assign m_sar   = sel ? 16'(sar_b)  : 16'(sar_a);
    assign m_dout  = sel ? 16'(dout_b) : 16'(dout_a);
    assign m_cb    = sel ? 16'(cb_b)   : 16'(cb_a);
    assign m_fta   = sel ? 16'(fta_b)  : 16'(fta_a);
    assign m_ftb   = sel ? 16'(ftb_b)  : 16'(ftb_a);
    assign m_eoc   = sel ? eoc_b   : eoc_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_ovr   = sel ? ovr_b   : ovr_a;
    assign m_cclk  = sel ? cclk_b  : cclk_a;
    assign m_sclk  = sel ? sclk_b  : sclk_a;
    assign m_sclkn = sel ? sclkn_b : sclkn_a;
    assign m_drain = sel ? drain_b : drain_a;
    assign m_fsel  = sel ? fsel_b  : fsel_a;
    assign m_fup   = sel ? fup_b   : fup_a;

    // Ideal comparator; optionally overridden during the boundary decide cycle
    assign cmp = (force_mode != 0 && strobe_n == (sel ? CB + 1 : CA + 1) && m_busy && !m_cclk)
                 ? (force_mode == 1) : (vin >= m_sar);

    always @(posedge clk) strobe_n <= !m_busy ? 0 : strobe_n + int'(m_cclk);

    sar2_logic_param #(
        .COARSE_BITS(CA), .FINE_BITS(FA), .SAMPLE_CYCLES(SA), .DRAIN_CYCLES(DA),
        .SETTLE_CYCLES(TA)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .cnvst_i(cnvst & ~sel), .cont_i(cont & ~sel), .cmp_out_i(cmp),
        .sar_o(sar_a), .dout_o(dout_a), .eoc_o(eoc_a), .busy_o(busy_a), .overrun_o(ovr_a),
        .cmp_clk_o(cclk_a), .s_clk_o(sclk_a), .s_clk_n_o(sclkn_a), .drain_sw_o(drain_a),
        .coarse_btm_o(cb_a), .fine_sel_o(fsel_a), .fine_up_o(fup_a),
        .fine_top_a_o(fta_a), .fine_top_b_o(ftb_a)
    );

    sar2_logic_param #(
        .COARSE_BITS(CB), .FINE_BITS(FB), .SAMPLE_CYCLES(SB), .DRAIN_CYCLES(DB),
        .SETTLE_CYCLES(TB)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .cnvst_i(cnvst & sel), .cont_i(cont & sel), .cmp_out_i(cmp),
        .sar_o(sar_b), .dout_o(dout_b), .eoc_o(eoc_b), .busy_o(busy_b), .overrun_o(ovr_b),
        .cmp_clk_o(cclk_b), .s_clk_o(sclk_b), .s_clk_n_o(sclkn_b), .drain_sw_o(drain_b),
        .coarse_btm_o(cb_b), .fine_sel_o(fsel_b), .fine_up_o(fup_b),
        .fine_top_a_o(fta_b), .fine_top_b_o(ftb_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 32'(m_busy), 0);
        check({tag, "_sclk"}, 32'(m_sclk), 1);
        check({tag, "_sclkn"}, 32'(m_sclkn), 0);
        check({tag, "_cmpclk"}, 32'(m_cclk), 0);
        check({tag, "_drain"}, 32'(m_drain), 0);
        check({tag, "_sar"}, 32'(m_sar), 0);
        check({tag, "_dout"}, 32'(m_dout), 0);
        check({tag, "_eoc"}, 32'(m_eoc), 0);
        check({tag, "_ovr"}, 32'(m_ovr), 0);
        check({tag, "_fsel"}, 32'(m_fsel), 0);
        check({tag, "_fup"}, 32'(m_fup), 0);
        check({tag, "_fta"}, 32'(m_fta), 0);
        check({tag, "_ftb"}, 32'(m_ftb), 0);
        check({tag, "_cbtm"}, 32'(m_cb), 0);
    endtask

    // Ideal two-step SAR: result equals the input; each fine decision equals the input bit
    function automatic void model(input int v, input int fmode, input int n, input int f,
                                  output int dout, output int fu, output int fta,
                                  output int ftb);
        int coarse;
        dout   = v & ((1 << n) - 1);
        coarse = (dout >> f) << f;
        fu     = (fmode == 1) ? 1 : (fmode == 2) ? 0 : int'(dout >= coarse);
        fta    = 0;
        ftb    = 0;
        for (int i = 0; i < f; i++) begin
            if ((((dout >> i) & 1) ^ fu) != 0) fta |= (1 << i);
            else                               ftb |= (1 << i);
        end
    endfunction

    task automatic run_conv(input int v, input int fmode, input int ovr_k, input int rst_k,
                            input bit do_start);
        int n, f, c, d, t, exp_k, k, w, eoc_k, busy_n, drains, strobes, ovr_n, bad, idle_busy;
        int e_dout, e_fu, e_fta, e_ftb;
        bit did_rst;
        n = sel ? NB : NA; f = sel ? FB : FA; c = sel ? CB : CA;
        d = sel ? DB : DA; t = sel ? TB : TA;
        exp_k = d + 2 * c + 2 + t + 2 * f + 1;
        model(v, fmode, n, f, e_dout, e_fu, e_fta, e_ftb);
        vin = 16'(v);
        force_mode = fmode;
        if (do_start) begin
            cnvst = 1'b1;
            tick();
            cnvst = 1'b0;
            w = 0;
            while (!m_busy && w < 20) begin
                tick();
                w++;
            end
        end
        check("start", 32'(m_busy), 1);
        k = 0; eoc_k = -1; busy_n = 0; drains = 0; strobes = 0; ovr_n = 0; bad = 0;
        did_rst = 1'b0;
        while (eoc_k < 0 && k < 80 && !did_rst) begin
            busy_n  += int'(m_busy);
            drains  += int'(m_drain);
            strobes += int'(m_cclk);
            ovr_n   += int'(m_ovr);
            if (m_sclk == m_busy || m_sclkn == m_sclk) bad++;
            if (m_eoc) begin
                eoc_k = k;
            end else begin
                cnvst = (k == ovr_k);
                rst   = (k == rst_k);
                tick();
                k++;
                if (rst) begin
                    rst = 1'b0;
                    did_rst = 1'b1;
                end
            end
        end
        cnvst = 1'b0;
        if (did_rst) begin
            check_reset("midrst");
            return;
        end
        check("eoc_lat", 32'(eoc_k), 32'(exp_k));
        check("busy_len", 32'(busy_n), 32'(exp_k));
        check("drain_len", 32'(drains), 32'(d));
        check("strobes", 32'(strobes), 32'(c + 1 + f));
        check("overrun", 32'(ovr_n), (ovr_k >= 0) ? 1 : 0);
        check("sclk", 32'(bad), 0);
        check("dout", 32'(m_dout), 32'(e_dout));
        check("fine_up", 32'(m_fup), 32'(e_fu));
        check("fine_top_a", 32'(m_fta), 32'(e_fta));
        check("fine_top_b", 32'(m_ftb), 32'(e_ftb));
        check("fine_sel_hi", 32'(m_fsel), 1);
        check("coarse_btm", 32'(m_cb), 32'(e_dout >> f));
        tick();
        check("eoc_pulse", 32'(m_eoc), 0);
        check("dout_hold", 32'(m_dout), 32'(e_dout));
        check("fine_sel_lo", 32'(m_fsel), 0);
        check("sar_init", 32'(m_sar), 32'(1 << (n - 1)));
        idle_busy = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            idle_busy += int'(m_busy);
        end
        check("noextra", 32'(idle_busy), 0);
    endtask

    initial begin
        int eocs[$];
        bit dropped;
        rst = 1'b1; cnvst = 1'b0; cont = 1'b0; sel = 1'b0; vin = '0; force_mode = 0;
        repeat (3) tick();
        check_reset("por");
        rst = 1'b0;
        tick();
        // Request one cycle after reset release must be latched until the sample window fills
        vin = 16'h00A5;
        cnvst = 1'b1;
        tick();
        cnvst = 1'b0;
        check("pend_wait", 32'(m_busy), 0);
        tick();
        check("pend_start", 32'(m_busy), 1);
        run_conv(32'hA5, 0, -1, -1, 1'b0);

        run_conv(32'h00, 0, -1, -1, 1'b1);
        run_conv(32'hFF, 0, -1, -1, 1'b1);
        run_conv(32'h5A, 1, -1, -1, 1'b1);
        run_conv(32'h96, 2, -1, -1, 1'b1);
        run_conv(32'h41, 0, 3, -1, 1'b1);
        for (int r = 0; r < 6; r++)
            run_conv(int'($urandom_range(0, 255)), int'($urandom_range(0, 2)), -1, -1, 1'b1);

        // Continuous mode, then drop cont partway into the fourth conversion
        vin = 16'h003C;
        force_mode = 0;
        cont = 1'b1;
        dropped = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (m_eoc) begin
                eocs.push_back(cyc);
                check("cont_dout", 32'(m_dout), 32'h3C);
            end
            if (!dropped && eocs.size() == 3 && cyc == eocs[2] + 8) begin
                check("cont_busy_at_drop", 32'(m_busy), 1);
                cont = 1'b0;
                dropped = 1'b1;
            end
            tick();
        end
        cont = 1'b0;
        check("cont_count", 32'(eocs.size()), 4);
        for (int i = 1; i < eocs.size(); i++)
            check("cont_period", 32'(eocs[i] - eocs[i-1]), 32'(2 * CA + 2 * FA + DA + TA + 3 + SA + 1));
        check("cont_idle", 32'(m_busy), 0);

        sel = 1'b1;
        repeat (2) tick();
        run_conv(32'h2B7, 0, -1, -1, 1'b1);
        run_conv(32'h2B7, 0, -1, DB + 2 * CB + 2 + TB, 1'b1);
        run_conv(32'h2B7, 0, -1, -1, 1'b1);
        for (int r = 0; r < 3; r++)
            run_conv(int'($urandom_range(0, 1023)), int'($urandom_range(0, 2)), -1, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
